// File: rtl/bandit.sv
`default_nettype none
// ============================================================================
// Module      : bandit
// Description : 256-arm epsilon-greedy bandit agent. It emits an action, takes
//               a signed reward and updates an exponentially averaged table.
// Revision    : 1.0 - initial release
// ============================================================================
module bandit #(
    parameter int          STEP_SHIFT = 2,
    parameter logic [8:0]  EPSILON    = 9'd8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reward_valid,
    input  logic [7:0] reward_data,
    output logic       reward_ready,
    output logic       action_valid,
    output logic [7:0] action_data,
    input  logic       action_ready
);

    localparam logic [1:0]        c_st_select = 2'd0;
    localparam logic [1:0]        c_st_action = 2'd1;
    localparam logic [1:0]        c_st_reward = 2'd2;
    localparam logic [1:0]        c_st_update = 2'd3;
    localparam logic signed [7:0] c_val_min   = 8'sh80;
    localparam logic signed [7:0] c_val_max   = 8'sh7F;

    // Reset deliberately leaves the table alone so externally preloaded values survive.
    logic signed [7:0] action_value_table [0:255] = '{default: 8'sh00};

    logic [1:0]        r_state, w_state_nxt;
    logic              r_first, w_first_nxt;
    logic [7:0]        r_idx, w_idx_nxt;
    logic [7:0]        r_best_idx, w_best_idx_nxt;
    logic signed [7:0] r_best_val, w_best_val_nxt;
    logic [15:0]       r_lfsr, w_lfsr_nxt;
    logic [7:0]        r_action_data, w_action_data_nxt;
    logic              r_action_valid, w_action_valid_nxt;
    logic              r_reward_ready, w_reward_ready_nxt;
    logic signed [7:0] r_reward, w_reward_nxt;

    logic              w_lfsr_fb;
    logic signed [7:0] w_entry;
    logic              w_entry_better;
    logic signed [7:0] w_q;
    logic signed [8:0] w_diff;
    logic signed [8:0] w_delta;
    logic signed [9:0] w_sum;
    logic signed [7:0] w_q_new;

    assign w_lfsr_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_entry        = action_value_table[r_idx];
    // Strictly greater keeps the lowest index on ties.
    assign w_entry_better = (w_entry > r_best_val);

    assign w_q     = action_value_table[r_action_data];
    assign w_diff  = {r_reward[7], r_reward} - {w_q[7], w_q};
    assign w_delta = w_diff >>> STEP_SHIFT;
    assign w_sum   = {w_q[7], w_q[7], w_q} + {w_delta[8], w_delta};
    assign w_q_new = (w_sum > 10'sd127)  ? c_val_max :
                     (w_sum < -10'sd128) ? c_val_min : w_sum[7:0];

    always_comb begin
        w_state_nxt        = r_state;
        w_first_nxt        = r_first;
        w_idx_nxt          = r_idx;
        w_best_idx_nxt     = r_best_idx;
        w_best_val_nxt     = r_best_val;
        w_lfsr_nxt         = r_lfsr;
        w_action_data_nxt  = r_action_data;
        w_action_valid_nxt = r_action_valid;
        w_reward_ready_nxt = r_reward_ready;
        w_reward_nxt       = r_reward;
        case (r_state)
            c_st_select: begin
                if (r_first) begin
                    w_first_nxt = 1'b0;
                    w_lfsr_nxt  = {r_lfsr[14:0], w_lfsr_fb};
                end
                if (r_first && ({1'b0, r_lfsr[15:8]} < EPSILON)) begin
                    w_action_data_nxt = r_lfsr[7:0];
                    w_state_nxt       = c_st_action;
                end else begin
                    // The entry cycle of a greedy pass already examines index 0.
                    if (w_entry_better) begin
                        w_best_val_nxt = w_entry;
                        w_best_idx_nxt = r_idx;
                    end
                    if (r_idx == 8'hFF) begin
                        w_action_data_nxt = w_entry_better ? r_idx : r_best_idx;
                        w_state_nxt       = c_st_action;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
            end
            c_st_action: begin
                if (!r_action_valid) begin
                    w_action_valid_nxt = 1'b1;
                end else if (action_ready) begin
                    w_action_valid_nxt = 1'b0;
                    w_reward_ready_nxt = 1'b1;
                    w_state_nxt        = c_st_reward;
                end
            end
            c_st_reward: begin
                if (reward_valid && r_reward_ready) begin
                    w_reward_nxt       = reward_data;
                    w_reward_ready_nxt = 1'b0;
                    w_state_nxt        = c_st_update;
                end
            end
            default: begin
                w_state_nxt    = c_st_select;
                w_first_nxt    = 1'b1;
                w_idx_nxt      = 8'd0;
                w_best_idx_nxt = 8'd0;
                w_best_val_nxt = c_val_min;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= c_st_select;
            r_first        <= 1'b1;
            r_idx          <= 8'd0;
            r_best_idx     <= 8'd0;
            r_best_val     <= c_val_min;
            r_lfsr         <= LFSR_SEED;
            r_action_data  <= 8'd0;
            r_action_valid <= 1'b0;
            r_reward_ready <= 1'b0;
            r_reward       <= 8'sh00;
        end else begin
            r_state        <= w_state_nxt;
            r_first        <= w_first_nxt;
            r_idx          <= w_idx_nxt;
            r_best_idx     <= w_best_idx_nxt;
            r_best_val     <= w_best_val_nxt;
            r_lfsr         <= w_lfsr_nxt;
            r_action_data  <= w_action_data_nxt;
            r_action_valid <= w_action_valid_nxt;
            r_reward_ready <= w_reward_ready_nxt;
            r_reward       <= w_reward_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && (r_state == c_st_update)) begin
            action_value_table[r_action_data] <= w_q_new;
        end
    end

    assign action_valid = r_action_valid;
    assign action_data  = r_action_data;
    assign reward_ready = r_reward_ready;

endmodule
`default_nettype wire

// File: tb/tb_bandit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bandit
// Description : Directed self-checking bench for the bandit agent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bandit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       reward_valid = 1'b0;
    logic [7:0] reward_data = 8'd0;
    logic       reward_ready;
    logic       action_valid;
    logic [7:0] action_data;
    logic       action_ready = 1'b0;

    logic       x_reset = 1'b0;
    logic       x_reward_valid = 1'b0;
    logic [7:0] x_reward_data = 8'd0;
    logic       x_reward_ready;
    logic       x_action_valid;
    logic [7:0] x_action_data;
    logic       x_action_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    bandit #(.STEP_SHIFT(2), .EPSILON(9'd0), .LFSR_SEED(16'hACE1)) dut (
        .clock       (clock),
        .reset       (reset),
        .reward_valid(reward_valid),
        .reward_data (reward_data),
        .reward_ready(reward_ready),
        .action_valid(action_valid),
        .action_data (action_data),
        .action_ready(action_ready)
    );

    bandit #(.STEP_SHIFT(2), .EPSILON(9'd256), .LFSR_SEED(16'hACE1)) dut_x (
        .clock       (clock),
        .reset       (x_reset),
        .reward_valid(x_reward_valid),
        .reward_data (x_reward_data),
        .reward_ready(x_reward_ready),
        .action_valid(x_action_valid),
        .action_data (x_action_data),
        .action_ready(x_action_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic signed [7:0] v);
        for (int i = 0; i < 256; i++) dut.action_value_table[i] = v;
    endtask

    // Counts rising edges until action_valid, starting from the edge after the call.
    task automatic wait_action(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!action_valid && edges < 600);
    endtask

    task automatic transact(input logic [7:0] r);
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        reward_valid = 1'b1;
        reward_data  = r;
        tick();
        reward_valid = 1'b0;
        tick();
    endtask

    task automatic round(input string tag, input logic [7:0] exp_arm,
                         input logic [7:0] r, input logic signed [7:0] exp_q);
        int e;
        reset = 1'b1;
        wait_action(e);
        check({tag, "_valid"}, action_valid, 1);
        check({tag, "_arm"}, action_data, exp_arm);
        transact(r);
        check({tag, "_q"}, dut.action_value_table[exp_arm], exp_q);
    endtask

    initial begin
        int         e;
        logic [7:0] held;

        // Reset held for 5 edges with the table preloaded to 5.
        tick();
        fill(8'sd5);
        repeat (4) tick();
        check("rst_valid", action_valid, 0);
        check("rst_ready", reward_ready, 0);
        check("rst_data", action_data, 0);

        reset = 1'b1;
        wait_action(e);
        check("lat_edges", e, 257);
        check("lat_arm", action_data, 0);
        check("lat_tab0", dut.action_value_table[0], 5);

        held = action_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", action_valid, 1);
            check("bp_data", action_data, held);
        end
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        check("hs_valid", action_valid, 0);
        check("hs_ready", reward_ready, 1);

        reward_data = 8'h80;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rw_ready", reward_ready, 1);
        end
        check("rw_tab0", dut.action_value_table[0], 5);
        reward_valid = 1'b1;
        reward_data  = 8'h00;
        tick();
        reward_valid = 1'b0;
        check("rw_consumed", reward_ready, 0);
        tick();
        check("upd_tab0", dut.action_value_table[0], 3);

        wait_action(e);
        check("next_valid", action_valid, 1);
        check("next_arm", action_data, 1);

        // Abort from REWARD: a reward offered on the reset edge must not be written.
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        reward_valid = 1'b1;
        reward_data  = 8'h9C;
        reset        = 1'b0;
        tick();
        reward_valid = 1'b0;
        check("rm_valid", action_valid, 0);
        check("rm_ready", reward_ready, 0);
        check("rm_data", action_data, 0);
        tick();
        check("rm_tab1", dut.action_value_table[1], 5);
        reset = 1'b1;
        wait_action(e);
        check("rm_edges", e, 257);
        check("rm_arm", action_data, 1);

        reset = 1'b0; tick();
        fill(8'sd5);
        dut.action_value_table[200] = 8'sd7;
        dut.action_value_table[17]  = 8'sh80;
        tick();
        round("amax", 8'd200, 8'd7, 8'sd7);

        reset = 1'b0; tick();
        fill(8'sd5);
        dut.action_value_table[10] = 8'sd9;
        dut.action_value_table[20] = 8'sd9;
        tick();
        round("tie", 8'd10, 8'd9, 8'sd9);

        reset = 1'b0; tick(); fill(8'sd5); tick();
        round("q5r3", 8'd0, 8'd3, 8'sd4);

        reset = 1'b0; tick(); fill(8'sh80); tick();
        round("qminrmax", 8'd0, 8'h7F, -8'sd65);

        reset = 1'b0; tick(); fill(8'sd0); tick();
        round("q0rm1", 8'd0, 8'hFF, -8'sd1);

        reset = 1'b0; tick(); fill(8'sd3); tick();
        round("q3r3", 8'd0, 8'd3, 8'sd3);

        // Exploring instance: the first decision uses the seed directly.
        x_reset = 1'b1;
        e = 0;
        do begin
            tick();
            e++;
        end while (!x_action_valid && e < 600);
        check("x_edges", e, 2);
        check("x_data", x_action_data, 8'hE1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
